// File: rtl/load_aligner_pkg.sv
// Shared definitions for the dmem load path: size codes, FSM encoding,
// captured-request payload and the misalignment predicate.
package load_aligner_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Request fields kept for extraction once dmem answers
   typedef struct packed {
      logic [1:0] off;
      logic [1:0] size;
      logic       uns;
   } ld_req_t;

   // Halfwords need an even address, words (10 and 11) a word-aligned one
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      if (size >= SZ_WORD)
         mis = (off != 2'b00);
      else if (size == SZ_HALF)
         mis = off[0];
      else
         mis = 1'b0;
      return mis;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a little-endian dmem word.
module load_extract
   import load_aligner_pkg::*;
(
   input  logic [31:0] raw_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   output logic [31:0] result_c_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane, then extend it to 32 bits
   always_comb begin
      byte_sel = raw_i[7:0];
      case (off_i)
         2'b00:   byte_sel = raw_i[7:0];
         2'b01:   byte_sel = raw_i[15:8];
         2'b10:   byte_sel = raw_i[23:16];
         default: byte_sel = raw_i[31:24];
      endcase
      half_sel   = off_i[1] ? raw_i[31:16] : raw_i[15:0];
      result_c_o = raw_i;
      if (size_i == SZ_BYTE)
         result_c_o = {{24{byte_sel[7] & ~uns_i}}, byte_sel};
      else if (size_i == SZ_HALF)
         result_c_o = {{16{half_sel[15] & ~uns_i}}, half_sel};
   end

endmodule

// File: rtl/load_aligner.sv
// Load side of the dmem interface: one request at a time, word-aligned read,
// bounded wait for data, aligned/extended result with misalign/timeout flags.
module load_aligner
   import load_aligner_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] addr,
   input  logic [1:0]  memr,
   input  logic        uns,
   output logic        dmem_re,
   output logic [31:0] dmem_addr,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        rdata_valid,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        timeout
);

   state_e           state_q, state_d;
   ld_req_t          req_q, req_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_ready_q, req_ready_d;
   logic             dmem_re_q, dmem_re_d;
   logic [31:0]      dmem_addr_q, dmem_addr_d;
   logic             rdata_valid_q, rdata_valid_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             misalign_q, misalign_d;
   logic             timeout_q, timeout_d;
   logic [31:0]      extracted;

   load_extract u_extract (
      .raw_i      (dmem_rdata),
      .off_i      (req_q.off),
      .size_i     (req_q.size),
      .uns_i      (req_q.uns),
      .result_c_o (extracted)
   );

   // Next-state, capture and registered-output decode
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      cnt_d       = cnt_q;
      dmem_addr_d = dmem_addr_q;
      rdata_d     = rdata_q;
      misalign_d  = misalign_q;
      timeout_d   = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_d.off   = addr[1:0];
               req_d.size  = memr;
               req_d.uns   = uns;
               dmem_addr_d = {addr[31:2], 2'b00};
               if (is_misaligned(memr, addr[1:0])) begin
                  state_d    = ST_RESP;
                  rdata_d    = ERR_DATA;
                  misalign_d = 1'b1;
                  timeout_d  = 1'b0;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d = CNT_W'(TIMEOUT);
            if (dmem_rvalid) begin
               state_d    = ST_RESP;
               rdata_d    = extracted;
               misalign_d = 1'b0;
               timeout_d  = 1'b0;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // rvalid takes priority over a counter that expires this cycle
            if (dmem_rvalid) begin
               state_d    = ST_RESP;
               rdata_d    = extracted;
               misalign_d = 1'b0;
               timeout_d  = 1'b0;
            end else if (cnt_q <= CNT_W'(1)) begin
               state_d    = ST_RESP;
               cnt_d      = '0;
               rdata_d    = ERR_DATA;
               misalign_d = 1'b0;
               timeout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      req_ready_d   = (state_d == ST_IDLE);
      dmem_re_d     = (state_d == ST_ISSUE);
      rdata_valid_d = (state_d == ST_RESP);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         req_q         <= '0;
         cnt_q         <= '0;
         req_ready_q   <= 1'b0;
         dmem_re_q     <= 1'b0;
         dmem_addr_q   <= '0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= '0;
         misalign_q    <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         cnt_q         <= cnt_d;
         req_ready_q   <= req_ready_d;
         dmem_re_q     <= dmem_re_d;
         dmem_addr_q   <= dmem_addr_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_q       <= rdata_d;
         misalign_q    <= misalign_d;
         timeout_q     <= timeout_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign dmem_re     = dmem_re_q;
   assign dmem_addr   = dmem_addr_q;
   assign rdata_valid = rdata_valid_q;
   assign rdata       = rdata_q;
   assign misalign    = misalign_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_load_aligner.sv
// Bench for load_aligner: two instances (TIMEOUT 16 and 4) share stimulus,
// each is checked against an arithmetic model of the load rules.
module tb_load_aligner;

   localparam int WIN = 22;

   logic        clk = 1'b0;
   logic        rst, req_valid, uns, dmem_rvalid;
   logic [31:0] addr, dmem_rdata;
   logic [1:0]  memr;

   logic        req_ready   [2];
   logic        dmem_re     [2];
   logic [31:0] dmem_addr   [2];
   logic        rdata_valid [2];
   logic [31:0] rdata       [2];
   logic        misalign    [2];
   logic        timeout     [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   load_aligner #(.TIMEOUT(16)) u_dut16 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
      .addr(addr), .memr(memr), .uns(uns), .dmem_re(dmem_re[0]),
      .dmem_addr(dmem_addr[0]), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .rdata_valid(rdata_valid[0]), .rdata(rdata[0]), .misalign(misalign[0]),
      .timeout(timeout[0])
   );

   load_aligner #(.TIMEOUT(4)) u_dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
      .addr(addr), .memr(memr), .uns(uns), .dmem_re(dmem_re[1]),
      .dmem_addr(dmem_addr[1]), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .rdata_valid(rdata_valid[1]), .rdata(rdata[1]), .misalign(misalign[1]),
      .timeout(timeout[1])
   );

   typedef struct {
      logic [31:0] a;
      logic [1:0]  sz;
      logic        u;
      int          delay;
      logic [31:0] word;
      logic [31:0] exp;
      logic        mis;
   } vec_t;

   function automatic int tout(input int d);
      return (d == 0) ? 16 : 4;
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   // Access must start on a multiple of its own size
   function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] sz);
      return (a % nbytes(sz)) != 0;
   endfunction

   // Shift the addressed bytes down, mask to size, extend by value
   function automatic logic [31:0] ref_ext(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
      longint unsigned v;
      int n, lane;
      n    = nbytes(sz);
      lane = (n == 4) ? 0 : int'(a % 4);
      v    = (64'(word) >> (8 * lane)) & ((64'd1 << (8 * n)) - 64'd1);
      if (!u && n < 4 && v >= (64'd1 << (8 * n - 1)))
         v = v + (64'd1 << 32) - (64'd1 << (8 * n));
      return 32'(v);
   endfunction

   task automatic wait_ready(input string name);
      int guard = 0;
      @(negedge clk);
      while (!(req_ready[0] && req_ready[1]) && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      chk({name, ":ready_wait"}, 0, 32'(req_ready[0] && req_ready[1]), 32'd1);
   endtask

   // One load; delay = cycles after the dmem_re cycle until rvalid, -1 = never
   task automatic do_load(input string name, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input int delay, input logic [31:0] word,
                          input logic [31:0] exp_data, input logic exp_mis);
      int          nvalid [2];
      int          vk     [2];
      int          nre    [2];
      int          rdy_k  [2];
      logic [31:0] got_rd [2];
      logic [31:0] re_adr [2];
      logic        got_mis[2];
      logic        got_to [2];
      for (int d = 0; d < 2; d++) begin
         nvalid[d] = 0; vk[d] = -1; nre[d] = 0; rdy_k[d] = -1;
         got_rd[d] = 'x; re_adr[d] = 'x; got_mis[d] = 1'bx; got_to[d] = 1'bx;
      end
      wait_ready(name);
      addr = a; memr = sz; uns = u; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      addr      = $urandom;
      for (int k = 0; k < WIN; k++) begin
         if (k > 0) @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rdata_valid[d]) begin
               nvalid[d]++; vk[d] = k; got_rd[d] = rdata[d];
               got_mis[d] = misalign[d]; got_to[d] = timeout[d];
            end
            if (dmem_re[d]) begin
               nre[d]++; re_adr[d] = dmem_addr[d];
            end
            if (req_ready[d] && rdy_k[d] < 0) rdy_k[d] = k;
         end
         dmem_rvalid = (k == delay);
         dmem_rdata  = (k == delay) ? word : $urandom;
      end
      dmem_rvalid = 1'b0;
      for (int d = 0; d < 2; d++) begin
         logic to;
         int   lat;
         to  = !exp_mis && (delay < 0 || delay > tout(d));
         lat = exp_mis ? 0 : (to ? tout(d) + 1 : delay + 1);
         chk({name, ":valid_count"}, d, 32'(nvalid[d]), 32'd1);
         chk({name, ":latency"},     d, 32'(vk[d]), 32'(lat));
         chk({name, ":rdata"},       d, got_rd[d], (to || exp_mis) ? 32'h0 : exp_data);
         chk({name, ":misalign"},    d, 32'(got_mis[d]), 32'(exp_mis));
         chk({name, ":timeout"},     d, 32'(got_to[d]), 32'(to));
         chk({name, ":re_count"},    d, 32'(nre[d]), exp_mis ? 32'd0 : 32'd1);
         if (!exp_mis) chk({name, ":dmem_addr"}, d, re_adr[d], a & 32'hFFFF_FFFC);
         chk({name, ":ready_back"},  d, 32'(rdy_k[d]), 32'(lat + 1));
      end
   endtask

   task automatic chk_reset_vals(input string name);
      for (int d = 0; d < 2; d++) begin
         chk({name, ":req_ready"},   d, 32'(req_ready[d]), 32'd0);
         chk({name, ":dmem_re"},     d, 32'(dmem_re[d]), 32'd0);
         chk({name, ":dmem_addr"},   d, dmem_addr[d], 32'd0);
         chk({name, ":rdata_valid"}, d, 32'(rdata_valid[d]), 32'd0);
         chk({name, ":rdata"},       d, rdata[d], 32'd0);
         chk({name, ":misalign"},    d, 32'(misalign[d]), 32'd0);
         chk({name, ":timeout"},     d, 32'(timeout[d]), 32'd0);
      end
   endtask

   initial begin
      vec_t tbl[13];
      int   nv;
      tbl[0]  = '{32'h100, 2'b00, 1'b0,  0, 32'h80FF7F01, 32'h00000001, 1'b0};
      tbl[1]  = '{32'h101, 2'b00, 1'b0,  1, 32'h80FF7F01, 32'h0000007F, 1'b0};
      tbl[2]  = '{32'h102, 2'b00, 1'b0,  2, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0};
      tbl[3]  = '{32'h103, 2'b00, 1'b0,  3, 32'h80FF7F01, 32'hFFFFFF80, 1'b0};
      tbl[4]  = '{32'h202, 2'b01, 1'b1,  0, 32'hBEEF1234, 32'h0000BEEF, 1'b0};
      tbl[5]  = '{32'h202, 2'b01, 1'b0,  1, 32'hBEEF1234, 32'hFFFFBEEF, 1'b0};
      tbl[6]  = '{32'h010, 2'b10, 1'b0,  5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      tbl[7]  = '{32'h003, 2'b01, 1'b0,  0, 32'h11111111, 32'h00000000, 1'b1};
      tbl[8]  = '{32'h006, 2'b10, 1'b0,  1, 32'h22222222, 32'h00000000, 1'b1};
      tbl[9]  = '{32'h040, 2'b10, 1'b0, -1, 32'h33333333, 32'h00000000, 1'b0};
      tbl[10] = '{32'h044, 2'b11, 1'b1,  4, 32'hA5A5C3C3, 32'hA5A5C3C3, 1'b0};
      tbl[11] = '{32'h201, 2'b00, 1'b1,  2, 32'h1234ABCD, 32'h000000AB, 1'b0};
      tbl[12] = '{32'h102, 2'b01, 1'b0,  0, 32'h7FFF0000, 32'h00007FFF, 1'b0};

      rst = 1'b1; req_valid = 1'b0; addr = '0; memr = '0; uns = 1'b0;
      dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals("init_rst");
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("init_ready", d, 32'(req_ready[d]), 32'd1);

      for (int i = 0; i < 13; i++)
         do_load($sformatf("vec%0d", i), tbl[i].a, tbl[i].sz, tbl[i].u, tbl[i].delay,
                 tbl[i].word, tbl[i].exp, tbl[i].mis);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, w;
         logic [1:0]  sz;
         logic        u;
         int          dl;
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC | 32'(($urandom_range(0, 1)) * 2);
         sz = 2'($urandom_range(0, 3));
         u  = 1'($urandom_range(0, 1));
         dl = int'($urandom_range(0, 7)) - 1;
         w  = $urandom;
         do_load($sformatf("rnd%0d", i), a, sz, u, dl, w, ref_ext(w, a, sz, u), ref_mis(a, sz));
      end

      // Leave a non-zero result behind so the reset visibly clears it
      do_load("pre_rst", 32'h44, 2'b10, 1'b0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);

      // Reset while waiting in WAIT; the late response must be dropped
      wait_ready("rst_seq");
      addr = 32'h80; memr = 2'b10; uns = 1'b0; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("mid_rst");
      rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      for (int d = 0; d < 2; d++) chk("rst_ready", d, 32'(req_ready[d]), 32'd1);
      nv = 0;
      for (int k = 0; k < 6; k++) begin
         for (int d = 0; d < 2; d++) if (rdata_valid[d]) nv++;
         @(negedge clk);
      end
      chk("rst_no_valid", 0, 32'(nv), 32'd0);

      do_load("post_rst", 32'h80, 2'b10, 1'b0, 2, 32'h0BADCAFE, 32'h0BADCAFE, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
